// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes scancodes,
// decodes make/break/shift into ASCII and buffers characters in a small FIFO.
module ps2_key_source #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} rx_state_t;

  // Synchronizers reset to the PS/2 idle level so release never looks like an edge.
  logic [1:0] clk_sync, data_sync;
  logic       sync_prev, sync_cur, fall, bit_in;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      sync_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the old value of the one before it.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      sync_prev <= sync_cur;
    end
  end

  assign sync_cur = clk_sync[1];
  assign bit_in   = data_sync[1];
  assign fall     = sync_prev & ~sync_cur;

  // Receiver FSM
  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          scan_valid, scan_valid_n;
  logic [7:0]    scan_code, scan_code_n;
  logic          frame_err_n;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      to_cnt     <= to_cnt_n;
      scan_valid <= scan_valid_n;
      scan_code  <= scan_code_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    scan_valid_n = 1'b0;
    scan_code_n  = scan_code;
    frame_err_n  = 1'b0;
    to_cnt_n     = (state == IDLE || fall) ? '0 : to_cnt + TW'(1);

    case (state)
      IDLE: if (fall && !bit_in) begin
        state_n   = SHIFT;
        bit_cnt_n = '0;
      end
      SHIFT: if (fall) begin
        shreg_n   = {bit_in, shreg[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        par_bit_n = bit_in;
        state_n   = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        if (bit_in && (^{par_bit, shreg})) begin
          scan_valid_n = 1'b1;
          scan_code_n  = shreg;
        end else begin
          frame_err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
      to_cnt_n    = '0;
    end
  end

  // Scancode to ASCII: {hit, code}. Letters come out upper case while shift is held.
  function automatic logic [8:0] map_key(input logic [7:0] code, input logic shift_on);
    logic [7:0] ch;
    logic       hit, letter;
    ch = 8'h00; hit = 1'b1; letter = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: begin
        letter = 1'b0;
        case (code)
          8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
          8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
          8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;  8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;
          default: hit = 1'b0;
        endcase
      end
    endcase
    if (letter && shift_on) ch = ch - 8'h20;
    return {hit, ch};
  endfunction

  // Decoder
  logic       brk, ext, shift;
  logic       char_wr;
  logic [7:0] char_wr_data;
  logic [8:0] mapped;

  assign mapped = map_key(scan_code, shift);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      brk          <= 1'b0;
      ext          <= 1'b0;
      shift        <= 1'b0;
      char_wr      <= 1'b0;
      char_wr_data <= '0;
    end else begin
      char_wr <= 1'b0;
      if (scan_valid) begin
        if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext) begin
            if (scan_code == 8'h12 || scan_code == 8'h59) begin
              shift <= ~brk;
            end else if (!brk && mapped[8]) begin
              char_wr      <= 1'b1;
              char_wr_data <= mapped[7:0];
            end
          end
        end
      end
    end
  end

  // Character FIFO with a registered head entry.
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_n;
  logic       empty, full, pop, push;
  logic [7:0] head_n;

  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign char_valid = ~empty;
  assign pop        = ~empty & char_ready;
  assign push       = char_wr & (~full | pop);
  assign rptr_n     = pop ? rptr + 1'b1 : rptr;

  always_comb begin
    head_n = char_data;
    if (push && rptr_n == wptr)
      head_n = char_wr_data;
    else if (rptr_n != wptr)
      head_n = mem[rptr_n[AW-1:0]];
  end

  // NOTE: storage array has no reset; only pointers and the head register need a known value.
  always_ff @(posedge clk50) begin
    if (push) mem[wptr[AW-1:0]] <= char_wr_data;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      char_data <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      rptr      <= rptr_n;
      char_data <= head_n;
      overflow  <= char_wr & full & ~pop;
    end
  end

endmodule

// File: tb/tb_ps2_key_source.sv
// Self-checking bench for ps2_key_source: directed frames plus a randomized
// scancode stream checked against a behavioural keyboard model.
module tb_ps2_key_source;

  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int H     = 20;

  logic       clk50, reset, ps2_clk, ps2_data, char_ready;
  logic [7:0] char_data;
  logic       char_valid, frame_err, overflow;

  ps2_key_source #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk50(clk50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observation of the consumer side.
  byte unsigned obs[$];
  int err_seen, ovf_seen, valid_cycles;

  always @(negedge clk50) begin
    if (!reset) begin
      if (char_valid && char_ready) obs.push_back(char_data);
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (char_valid) valid_cycles++;
    end
  end

  task automatic clear_obs();
    obs.delete();
    err_seen = 0; ovf_seen = 0; valid_cycles = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] code, input int nbits, input logic flip_par);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ flip_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par);
    send_bits(code, 11, flip_par);
    tick(2 * H);
  endtask

  task automatic check_obs(input string tag, input byte unsigned exp[$]);
    check({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF, exp[i]);
  endtask

  // Behavioural keyboard model: scancode stream -> expected characters.
  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  byte unsigned other_codes[4] = '{8'h05, 8'h76, 8'h0E, 8'h66};

  byte unsigned exp_q[$];
  bit m_brk, m_ext, m_shift;
  int m_err;

  task automatic model_code(input byte unsigned code, input bit good);
    if (!good) begin
      m_err++;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (!m_ext) begin
        if (code == 8'h12 || code == 8'h59) begin
          m_shift = !m_brk;
        end else if (!m_brk) begin
          for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) exp_q.push_back(8'((m_shift ? 8'h41 : 8'h61) + i));
          for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) exp_q.push_back(8'(8'h30 + i));
          if (code == 8'h29) exp_q.push_back(8'h20);
          if (code == 8'h5A) exp_q.push_back(8'h0D);
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk50);
    #1;
    if (rand_ready) char_ready = ($urandom_range(0, 3) != 0);
  end

  int lat;

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; char_ready = 1'b0;
    clear_obs();
    tick(3);
    check("rst_char_data", char_data, 8'h00);
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single lower-case 'a', with the stop-edge-to-valid latency measured.
    char_ready = 1'b1;
    clear_obs();
    send_bits(8'h1C, 10, 1'b0);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (char_valid && lat < 0) lat = k;
    end
    ps2_clk = 1'b1;
    tick(2 * H);
    check("latency_edges", lat, 5);
    check("a_valid_cycles", valid_cycles, 1);
    check_obs("a_data", '{8'h61});

    // Shift make/break around letters.
    clear_obs();
    send_frame(8'h12, 0); send_frame(8'h1C, 0); send_frame(8'hF0, 0);
    send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h12, 0);
    send_frame(8'h1C, 0);
    tick(10);
    check_obs("shift_seq", '{8'h41, 8'h61});
    check("shift_seq_err", err_seen, 0);

    // Parity error.
    clear_obs();
    send_frame(8'h1C, 1);
    tick(10);
    check("parity_err", err_seen, 1);
    check("parity_valid", valid_cycles, 0);

    // Timeout mid-frame, then recovery.
    clear_obs();
    send_bits(8'h29, 5, 0);
    tick(TO + 10);
    check("timeout_err", err_seen, 1);
    send_frame(8'h29, 0);
    tick(10);
    check("timeout_err_total", err_seen, 1);
    check_obs("timeout_recover", '{8'h20});

    // FIFO overflow with a stalled consumer.
    char_ready = 1'b0;
    clear_obs();
    send_frame(8'h16, 0); send_frame(8'h1E, 0); send_frame(8'h26, 0);
    send_frame(8'h25, 0); send_frame(8'h2E, 0); send_frame(8'h36, 0);
    tick(10);
    check("ovf_pulses", ovf_seen, 2);
    check("ovf_head_stable", char_data, 8'h31);
    check("ovf_valid", char_valid, 1'b1);
    char_ready = 1'b1;
    tick(10);
    check_obs("ovf_drain", '{8'h31, 8'h32, 8'h33, 8'h34});
    check("ovf_empty", char_valid, 1'b0);

    // Asynchronous reset mid-frame with two buffered characters.
    char_ready = 1'b0;
    clear_obs();
    send_frame(8'h16, 0); send_frame(8'h1E, 0);
    check("pre_rst_valid", char_valid, 1'b1);
    send_bits(8'h45, 5, 0);
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", char_valid, 1'b0);
    check("async_rst_data", char_data, 8'h00);
    tick(3);
    reset = 1'b0;
    tick(5);
    clear_obs();
    char_ready = 1'b1;
    send_frame(8'h45, 0);
    tick(10);
    check_obs("post_rst", '{8'h30});
    check("post_rst_err", err_seen, 0);

    // Randomized scancode stream against the model.
    clear_obs();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_shift = 0; m_err = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      byte unsigned code;
      bit bad;
      r = $urandom_range(0, 99);
      if (r < 45)      code = letter_codes[$urandom_range(0, 25)];
      else if (r < 60) code = digit_codes[$urandom_range(0, 9)];
      else if (r < 70) code = 8'hF0;
      else if (r < 75) code = 8'hE0;
      else if (r < 85) code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r < 90) code = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
      else             code = other_codes[$urandom_range(0, 3)];
      bad = ($urandom_range(0, 11) == 0);
      model_code(code, !bad);
      send_frame(code, bad);
    end
    rand_ready = 1'b0;
    tick(2);
    char_ready = 1'b1;
    tick(20);
    check_obs("rand_chars", exp_q);
    check("rand_errs", err_seen, m_err);
    check("rand_ovf", ovf_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
